// File: rtl/aes_pkg.sv
// ---------------------------------------------------------------------------
// aes_pkg
// Shared definitions for the AES-128 inverse last-round block.
//   - state_t / ST_*     : FSM state encoding for inv_last_round
//   - INV_SBOX, inv_sbox : AES inverse substitution table and lookup
//   - inv_shift_rows     : row r of the column-major state rotated right by r
//   - byte_at            : byte i of a 128-bit state ([127:120] is byte 0)
// ---------------------------------------------------------------------------
package aes_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_SUB  = 2'd1;
    localparam state_t ST_DONE = 2'd2;

    localparam logic [7:0] INV_SBOX [256] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

    function automatic logic [7:0] inv_sbox(input logic [7:0] b);
        return INV_SBOX[b];
    endfunction

    // Byte 0 sits in the most significant byte lane.
    function automatic logic [7:0] byte_at(input logic [127:0] s, input int i);
        return s[127 - 8*i -: 8];
    endfunction

    // Byte 4c+r is row r, column c. Output (r,c) takes input (r,(c-r) mod 4).
    function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127 - 8*(4*c + r) -: 8] = byte_at(s, 4*((c - r + 4) % 4) + r);
            end
        end
        return o;
    endfunction

endpackage

// File: rtl/inv_s_box.sv
// ---------------------------------------------------------------------------
// inv_s_box
// Purely combinational AES inverse S-box.
//   din  : input byte
//   dout : INV_SBOX(din)
// ---------------------------------------------------------------------------
module inv_s_box
    import aes_pkg::*;
(
    input  logic [7:0] din,
    output logic [7:0] dout
);

    assign dout = inv_sbox(din);

endmodule

// File: rtl/inv_last_round.sv
// ---------------------------------------------------------------------------
// inv_last_round
// First step of the AES-128 inverse cipher: computes
// InvSubBytes(InvShiftRows(data_in ^ round_key)) with NUM_SBOX inverse
// S-boxes reused over 16/NUM_SBOX cycles.
//   clk        : clock, all state updates on the rising edge
//   reset      : synchronous, active-low
//   in_valid   : data_in/round_key valid (ignored unless idle)
//   in_ready   : block idle and able to take a new input
//   data_in    : ciphertext, [127:120] = byte 0, column-major
//   round_key  : round-10 key, same byte order
//   out_valid  : data_out valid, held until out_ready
//   out_ready  : downstream accepts data_out
//   data_out   : result in DONE, zero otherwise
//   busy       : block is not idle
// ---------------------------------------------------------------------------
module inv_last_round
    import aes_pkg::*;
#(
    parameter int NUM_SBOX = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] data_in,
    input  logic [127:0] round_key,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] data_out,
    output logic         busy
);

    localparam int NUM_CHUNKS = 16 / NUM_SBOX;
    // A single-chunk configuration still needs a 1-bit counter to exist.
    localparam int CNT_W = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NUM_CHUNKS - 1);

    generate
        if (NUM_SBOX != 1 && NUM_SBOX != 2 && NUM_SBOX != 4 &&
            NUM_SBOX != 8 && NUM_SBOX != 16) begin : g_bad_num_sbox
            $error("inv_last_round: NUM_SBOX must be 1, 2, 4, 8 or 16");
        end
    endgenerate

    state_t             state_reg;
    state_t             state_next;
    logic [CNT_W-1:0]   cnt_reg;
    logic [CNT_W-1:0]   cnt_next;
    logic [127:0]       data_reg;
    logic [127:0]       data_next;

    logic [7:0]         sbox_in  [NUM_SBOX];
    logic [7:0]         sbox_out [NUM_SBOX];
    logic [127:0]       sub_result;

    // S-box lane gi always works on byte cnt*NUM_SBOX + gi of the state.
    generate
        for (genvar gi = 0; gi < NUM_SBOX; gi++) begin : g_sbox
            assign sbox_in[gi] = byte_at(data_reg, int'(cnt_reg) * NUM_SBOX + gi);

            inv_s_box u_inv_s_box (
                .din  (sbox_in[gi]),
                .dout (sbox_out[gi])
            );
        end
    endgenerate

    // Write the substituted chunk back into its own byte positions.
    always_comb begin
        sub_result = data_reg;
        for (int i = 0; i < NUM_SBOX; i++) begin
            sub_result[127 - 8*(int'(cnt_reg) * NUM_SBOX + i) -: 8] = sbox_out[i];
        end
    end

    // State, counter and data registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= '0;
            data_reg  <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            data_reg  <= data_next;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: if (in_valid)             state_next = ST_SUB;
            ST_SUB:  if (cnt_reg == CNT_LAST)  state_next = ST_DONE;
            ST_DONE: if (out_ready)            state_next = ST_IDLE;
            default:                           state_next = ST_IDLE;
        endcase
    end

    // Datapath next values. data_in/round_key only reach the register on an
    // accepted handshake, so unknowns on an idle bus never enter the state.
    always_comb begin
        cnt_next  = cnt_reg;
        data_next = data_reg;
        case (state_reg)
            ST_IDLE: begin
                if (in_valid) begin
                    data_next = inv_shift_rows(data_in ^ round_key);
                    cnt_next  = '0;
                end
            end
            ST_SUB: begin
                data_next = sub_result;
                cnt_next  = (cnt_reg == CNT_LAST) ? '0 : cnt_reg + 1'b1;
            end
            default: begin
                cnt_next  = cnt_reg;
                data_next = data_reg;
            end
        endcase
    end

    // Outputs depend on state only, so in_ready never follows in_valid.
    always_comb begin
        in_ready  = (state_reg == ST_IDLE);
        out_valid = (state_reg == ST_DONE);
        busy      = (state_reg != ST_IDLE);
        data_out  = (state_reg == ST_DONE) ? data_reg : '0;
    end

endmodule
